// File: rtl/multi_cycle_adder.sv
// Sequential WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice.
// One nibble is processed per clock, LSB first, under a start/busy/done handshake.
module multi_cycle_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             OF,
  output logic             ZF
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic [IW-1:0]    idx;
  logic             carry;

  logic [3:0]       na, nb, p, g, sum;
  logic [4:0]       c;
  logic [WIDTH-1:0] f_next;
  logic             last, launch;

  always_comb begin
    na = opa[4*idx +: 4];
    nb = opb[4*idx +: 4];
    p  = na ^ nb;
    g  = na & nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
    f_next = F;
    f_next[4*idx +: 4] = sum;
    last   = (idx == IW'(N - 1));
    launch = start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      F     <= '0;
      Cout  <= 1'b0;
      OF    <= 1'b0;
      ZF    <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      idx   <= '0;
      carry <= 1'b0;
    end else begin
      if (launch) begin
        opa   <= A;
        opb   <= sub ? ~B : B;
        carry <= sub ? 1'b1 : Cin;
        idx   <= '0;
        state <= RUN;
        busy  <= 1'b1;
      end
      case (state)
        IDLE: ;
        RUN: begin
          F     <= f_next;
          carry <= c[4];
          if (last) begin
            // Flags are registered on the same edge that writes the top nibble.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Cout  <= c[4];
            OF    <= c[3] ^ c[4];
            ZF    <= (f_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (!launch) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench for multi_cycle_adder at WIDTH=8 and WIDTH=32,
// comparing against a plain-arithmetic reference model.
module tb_multi_cycle_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sub8, cin8, busy8, done8, cout8, of8, zf8;
  logic [7:0]  a8, b8, f8;
  logic        start32, sub32, cin32, busy32, done32, cout32, of32, zf32;
  logic [31:0] a32, b32, f32;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_f, prev_f;
  logic        exp_c, exp_of, exp_zf;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .F(f8), .Cout(cout8), .OF(of8), .ZF(zf8)
  );

  multi_cycle_adder #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .A(a32), .B(b32), .Cin(cin32),
    .busy(busy32), .done(done32), .F(f32), .Cout(cout32), .OF(of32), .ZF(zf32)
  );

  function automatic logic [31:0] obs_f(input bit w32);
    return w32 ? f32 : {24'b0, f8};
  endfunction
  function automatic logic obs_busy(input bit w32);
    return w32 ? busy32 : busy8;
  endfunction
  function automatic logic obs_done(input bit w32);
    return w32 ? done32 : done8;
  endfunction
  function automatic logic obs_c(input bit w32);
    return w32 ? cout32 : cout8;
  endfunction
  function automatic logic obs_of(input bit w32);
    return w32 ? of32 : of8;
  endfunction
  function automatic logic obs_zf(input bit w32);
    return w32 ? zf32 : zf8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: F/Cout from a (WIDTH+1)-bit sum, OF from operand/result signs.
  task automatic drive(input bit w32, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    logic [32:0] s;
    logic [31:0] bop;
    logic [32:0] ci;
    bop = sub ? ~b : b;
    ci  = {32'b0, sub | cin};
    if (w32) begin
      s      = {1'b0, a} + {1'b0, bop} + ci;
      exp_f  = s[31:0];
      exp_c  = s[32];
      exp_of = (a[31] == bop[31]) && (exp_f[31] != a[31]);
      prev_f = f32;
      a32 = a; b32 = b; cin32 = cin; sub32 = sub; start32 = 1'b1;
    end else begin
      s      = {25'b0, a[7:0]} + {25'b0, bop[7:0]} + ci;
      exp_f  = {24'b0, s[7:0]};
      exp_c  = s[8];
      exp_of = (a[7] == bop[7]) && (exp_f[7] != a[7]);
      prev_f = {24'b0, f8};
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; start8 = 1'b1;
    end
    exp_zf = (exp_f == 32'b0);
  endtask

  task automatic finish(input bit w32, input string tag, input bit glitch);
    int cyc;
    int n;
    logic [31:0] part;
    n = w32 ? 8 : 2;
    part = w32 ? {prev_f[31:4], exp_f[3:0]} : {24'b0, prev_f[7:4], exp_f[3:0]};
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    chk({tag, "_busy_launch"}, {31'b0, obs_busy(w32)}, 32'd1);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (glitch && cyc == 2) begin start32 = 1'b1; a32 = $urandom; b32 = $urandom; end
      if (glitch && cyc == 3) start32 = 1'b0;
      if (cyc == 1) chk({tag, "_partial_f"}, obs_f(w32), part);
      chk({tag, "_busy_done_overlap"}, {31'b0, obs_busy(w32) & obs_done(w32)}, 32'd0);
      if (obs_done(w32)) break;
    end
    chk({tag, "_latency"}, cyc, n);
    chk({tag, "_f"}, obs_f(w32), exp_f);
    chk({tag, "_cout"}, {31'b0, obs_c(w32)}, {31'b0, exp_c});
    chk({tag, "_of"}, {31'b0, obs_of(w32)}, {31'b0, exp_of});
    chk({tag, "_zf"}, {31'b0, obs_zf(w32)}, {31'b0, exp_zf});
    chk({tag, "_busy_at_done"}, {31'b0, obs_busy(w32)}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start32 = 0; sub32 = 0; cin32 = 0; a32 = '0; b32 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_done", {31'b0, done32}, 32'd0);
    chk("rst_f", f32, 32'd0);
    chk("rst_flags", {29'b0, cout32, of32, zf32}, 32'd0);
    chk("rst_f8", {24'b0, f8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    drive(0, 32'h3C, 32'h0F, 1'b1, 1'b0); finish(0, "add8_3c_0f", 0);
    drive(0, 32'hFF, 32'h01, 1'b0, 1'b0); finish(0, "add8_ff_01", 0);
    drive(0, 32'h7F, 32'h01, 1'b0, 1'b0); finish(0, "add8_7f_01", 0);
    drive(0, 32'h05, 32'h07, 1'b0, 1'b1); finish(0, "sub8_05_07", 0);
    chk("sub8_f_const", {24'b0, f8}, 32'hFE);

    for (int i = 0; i < 6; i++) begin
      drive(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish(0, "rnd8", 0);
    end

    drive(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0); finish(1, "add32_ones", 0);
    // Back-to-back launch from the DONE cycle, with a start pulse mid-run.
    drive(1, 32'h1, 32'h2, 1'b0, 1'b0); finish(1, "add32_b2b", 1);
    chk("add32_b2b_f_const", f32, 32'h3);
    @(posedge clk); #1;
    chk("after_glitch_busy", {31'b0, busy32}, 32'd0);
    chk("after_glitch_done", {31'b0, done32}, 32'd0);
    chk("after_glitch_f_hold", f32, 32'h3);

    for (int i = 0; i < 6; i++) begin
      drive(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish(1, "rnd32", 0);
    end

    drive(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_rst_busy", {31'b0, busy32}, 32'd0);
    chk("midrun_rst_done", {31'b0, done32}, 32'd0);
    chk("midrun_rst_f", f32, 32'd0);
    chk("midrun_rst_flags", {29'b0, cout32, of32, zf32}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    chk("midrun_rst_no_done", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_adder.md
# multi_cycle_adder

Parametrised, multi-cycle adder/subtractor that computes WIDTH-bit `A + B + Cin` (or `A - B`) by reusing a single 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. It is the sequential, width-generic successor to the team's 4-bit CLA adder. It sits in the datapath labs as an area-lean ALU add path. A start/busy/done handshake lets a controller FSM launch an operation and wait for the result and flags.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 is the number of nibble steps.
- `clk`  input  1  rising-edge clock (only clock)
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  launch request, sampled on the rising edge
- `sub`  input  1  0 = add, 1 = subtract; sampled with `start`
- `A`  input  WIDTH  operand A; sampled with `start`
- `B`  input  WIDTH  operand B; sampled with `start`
- `Cin`  input  1  carry-in for add; ignored when `sub`=1
- `busy`  output  1  operation in progress
- `done`  output  1  one-cycle pulse when the result is valid
- `F`  output  WIDTH  result (sum or difference)
- `Cout`  output  1  carry out of bit WIDTH-1. For subtract, 1 = no borrow.
- `OF`  output  1  signed overflow
- `ZF`  output  1  F == 0

## Operation
- Reset is synchronous and active-high: one clock, `rst` sampled on the rising edge of `clk`. Reset has priority over every other input.
- Reset values: state IDLE, `busy`=0, `done`=0, `F`=0, `Cout`=0, `OF`=0, `ZF`=0. Internal step index = 0 and carry register = 0.
- States:
  - IDLE → RUN when `start`=1.
  - RUN → RUN while step index < N-1.
  - RUN → DONE after step N-1.
  - DONE → RUN if `start`=1 (back-to-back launch), otherwise DONE → IDLE.
- Launch (IDLE or DONE with `start`=1):
  - Latch A into an operand register.
  - Latch B into an operand register as `sub ? ~B : B`.
  - Load the carry register with `sub ? 1 : Cin`.
  - Clear the index to 0. `F` is not cleared at launch.
- RUN step k (k = 0..N-1):
  - The combinational 4-bit CLA slice adds nibble k of each operand register plus the carry register.
  - Write the 4-bit sum into F[4k+3:4k].
  - Store the slice carry-out in the carry register.
  - On step N-1, also capture the carry into bit WIDTH-1 for OF.
- On entry to DONE (registered at the same edge):
  - `Cout` = final carry.
  - `OF` = carry into MSB XOR carry out of MSB.
  - `ZF` = (complete F == 0).
- `start` while in RUN is ignored. It is neither queued nor aborting, and the operand registers are unchanged.
- `F`, `Cout`, `OF` and `ZF` hold their values from DONE until the next result, or until reset. During RUN, the upper nibbles of `F` still show the previous result.
- Width rule: all arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- `start` sampled high at edge E0 → `busy`=1 from E0 until edge E_N (N cycles).
- `done`=1 for exactly one cycle, after E_N. Flags and the full `F` are valid in that same cycle.
- Latency from start to done is N cycles. WIDTH=32 gives 8 cycles.
- Throughput with back-to-back `start` in DONE: one result per N+1 cycles.
- `busy` and `done` are never high in the same cycle.
- Reset asserted mid-RUN: next cycle is IDLE with all outputs zero. No `done` is produced for the aborted operation.
- `start` and `rst` high together: reset wins and the operation is not launched.

## Test plan
- WIDTH=8:
  - Add A=0x3C, B=0x0F, Cin=1, sub=0 → after 2 cycles, done pulse with F=0x4C, Cout=0, OF=0, ZF=0.
  - Add A=0xFF, B=0x01, Cin=0 → F=0x00, Cout=1, ZF=1, OF=0. Checks carry ripple across the nibble boundary.
  - Add A=0x7F, B=0x01, Cin=0 → F=0x80, OF=1, Cout=0.
  - Subtract A=0x05, B=0x07, sub=1 → F=0xFE, Cout=0 (borrow), OF=0.
- WIDTH=32, add A=0xFFFF_FFFF, B=0, Cin=1 → done exactly 8 cycles after start, F=0, Cout=1, ZF=1.
  - Then assert `start` in the DONE cycle with A=1, B=2 → F=3 after 8 more cycles.
  - A `start` pulse during RUN → no effect.
- Assert `rst` at step 2 of a WIDTH=32 operation → next cycle `busy`=0, all outputs 0, and no `done` is seen.
